fir_coef_ctrl: RTL and testbench

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

---
 rtl/fir_coef_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fir_coef_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_ctrl.sv
// Coefficient load controller: streams ORD+1 beats into the FIR coefficient RAM and gates the filter.
// Optional FIR_COEF_SCRUB_EN keeps a shadow copy and periodically rewrites it into the RAM.
module fir_coef_ctrl #(
  parameter int unsigned ORD          = 10,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned COEF_ADDR_W  = 4,
  parameter int unsigned SCRUB_PERIOD = 1024
) (
  input  logic                   clk_i_sig,
  input  logic                   rst_i_sig,
  input  logic                   cfg_start_i,
  input  logic [DATA_W-1:0]      cfg_coef_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  output logic [COEF_ADDR_W-1:0] coef_addr_o,
  output logic [DATA_W-1:0]      coef_o,
  output logic                   we_o,
  output logic                   fir_en_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [COEF_ADDR_W-1:0] LastIdx = COEF_ADDR_W'(ORD);

  if (ORD + 1 > 2 ** COEF_ADDR_W) begin : gen_addr_chk
    $error("fir_coef_ctrl: ORD+1 coefficients do not fit in COEF_ADDR_W address bits");
  end
  if (SCRUB_PERIOD < 1) begin : gen_period_chk
    $error("fir_coef_ctrl: SCRUB_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StScrub} state_e;

  state_e                 state_q, state_d;
  logic [COEF_ADDR_W-1:0] idx_q, idx_d;
  logic [COEF_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      coef_q, coef_d;
  logic                   we_q, we_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   fir_en_q, fir_en_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

`ifdef FIR_COEF_SCRUB_EN
  localparam int unsigned     CntW    = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCRUB_PERIOD - 1);

  logic [DATA_W-1:0] shadow_q [ORD+1];
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              shadow_vld_q, shadow_vld_d;
  logic              shadow_we;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    coef_d   = coef_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    fir_en_d = fir_en_q;
`ifdef FIR_COEF_SCRUB_EN
    cnt_d        = cnt_q;
    shadow_vld_d = shadow_vld_q;
    shadow_we    = 1'b0;
`endif
    // Filter re-enables one cycle after the final write has landed.
    if (done_q) fir_en_d = 1'b1;
    if (cfg_valid_i && (state_q != StLoad)) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cfg_start_i) begin
          state_d  = StLoad;
          idx_d    = '0;
          fir_en_d = 1'b0;
`ifdef FIR_COEF_SCRUB_EN
          cnt_d    = '0;
`endif
        end
`ifdef FIR_COEF_SCRUB_EN
        else if (shadow_vld_q) begin
          if (cnt_q == CntLast) begin
            state_d = StScrub;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
`endif
      end
      StLoad: begin
        if (cfg_start_i) err_d = 1'b1;
        if (cfg_valid_i) begin
          we_d   = 1'b1;
          addr_d = idx_q;
          coef_d = cfg_coef_i;
`ifdef FIR_COEF_SCRUB_EN
          shadow_we = 1'b1;
`endif
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
`ifdef FIR_COEF_SCRUB_EN
            cnt_d        = '0;
            shadow_vld_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + COEF_ADDR_W'(1);
          end
        end
      end
`ifdef FIR_COEF_SCRUB_EN
      StScrub: begin
        // A new load request abandons the scrub; the write for this cycle is dropped.
        if (cfg_start_i) begin
          state_d  = StLoad;
          idx_d    = '0;
          fir_en_d = 1'b0;
          cnt_d    = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = idx_q;
          coef_d = shadow_q[idx_q];
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + COEF_ADDR_W'(1);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StLoad);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_i_sig) begin
    if (rst_i_sig) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      addr_q   <= '0;
      coef_q   <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fir_en_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef FIR_COEF_SCRUB_EN
      cnt_q        <= '0;
      shadow_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      coef_q   <= coef_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fir_en_q <= fir_en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef FIR_COEF_SCRUB_EN
      cnt_q        <= cnt_d;
      shadow_vld_q <= shadow_vld_d;
`endif
    end
  end

`ifdef FIR_COEF_SCRUB_EN
  always_ff @(posedge clk_i_sig) begin
    if (shadow_we) shadow_q[idx_q] <= cfg_coef_i;
  end
`endif

  assign cfg_ready_o = ready_q;
  assign coef_addr_o = addr_q;
  assign coef_o      = coef_q;
  assign we_o        = we_q;
  assign fir_en_o    = fir_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Bench for fir_coef_ctrl: directed phases with random data and gaps, checked against a
// transaction-level model (expected-write queue, sticky error, enable timing).
module tb_fir_coef_ctrl;
  localparam int unsigned ORD          = 10;
  localparam int unsigned DATA_W       = 24;
  localparam int unsigned COEF_ADDR_W  = 4;
  localparam int unsigned SCRUB_PERIOD = 16;

  logic                   clk_i_sig = 1'b0;
  logic                   rst_i_sig;
  logic                   cfg_start_i;
  logic [DATA_W-1:0]      cfg_coef_i;
  logic                   cfg_valid_i;
  logic                   cfg_ready_o;
  logic [COEF_ADDR_W-1:0] coef_addr_o;
  logic [DATA_W-1:0]      coef_o;
  logic                   we_o;
  logic                   fir_en_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;

  fir_coef_ctrl #(
    .ORD         (ORD),
    .DATA_W      (DATA_W),
    .COEF_ADDR_W (COEF_ADDR_W),
    .SCRUB_PERIOD(SCRUB_PERIOD)
  ) dut (
    .clk_i_sig  (clk_i_sig),
    .rst_i_sig  (rst_i_sig),
    .cfg_start_i(cfg_start_i),
    .cfg_coef_i (cfg_coef_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .coef_addr_o(coef_addr_o),
    .coef_o     (coef_o),
    .we_o       (we_o),
    .fir_en_o   (fir_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i_sig = ~clk_i_sig;

  int errs   = 0;
  int checks = 0;

  // Reference model state
  bit                m_load, m_err, m_fir_en, en_pending;
  int                m_cnt;
  logic [DATA_W-1:0] m_shadow [ORD+1];
  int                ea_q [$];
  logic [DATA_W-1:0] ed_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i_sig);
    #1;
  endtask

  // One cycle: predict from the inputs now being driven, advance, compare.
  task automatic tick();
    bit acc, last, start_new;
    acc       = cfg_valid_i && m_load;
    start_new = cfg_start_i && !m_load;
    if ((cfg_valid_i && !m_load) || (cfg_start_i && m_load)) m_err = 1'b1;
    last = acc && (m_cnt == ORD);
    if (acc) begin
      ea_q.push_back(m_cnt);
      ed_q.push_back(cfg_coef_i);
      m_shadow[m_cnt] = cfg_coef_i;
      m_cnt++;
    end
    if (last) m_load = 1'b0;
    m_fir_en   = start_new ? 1'b0 : (en_pending ? 1'b1 : m_fir_en);
    en_pending = last;
    if (start_new) begin
      m_load = 1'b1;
      m_cnt  = 0;
    end
    step();
    chk("we", we_o, acc);
    if (we_o) begin
      if (ea_q.size() == 0) chk("wr_extra", we_o, 0);
      else begin
        chk("addr", coef_addr_o, ea_q.pop_front());
        chk("data", coef_o, ed_q.pop_front());
      end
    end
    chk("done", done_o, last);
    chk("err", err_o, m_err);
    chk("fir_en", fir_en_o, m_fir_en);
    chk("ready", cfg_ready_o, m_load);
    chk("busy", busy_o, m_load);
  endtask

  task automatic do_reset();
    rst_i_sig   = 1'b1;
    cfg_start_i = 1'b0;
    cfg_valid_i = 1'b0;
    step();
    m_load = 0; m_cnt = 0; m_err = 0; m_fir_en = 0; en_pending = 0;
    ea_q.delete();
    ed_q.delete();
    chk("rst_ready", cfg_ready_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_addr", coef_addr_o, 0);
    chk("rst_coef", coef_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fir_en", fir_en_o, 0);
    rst_i_sig = 1'b0;
  endtask

  // mode 0: back-to-back, data k+1; mode 1: valid every other cycle; mode 2: random gaps.
  task automatic beats(input int mode, input int start_at);
    for (int n = 0; n < 400 && m_load; n++) begin
      bit v;
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      cfg_valid_i = v;
      cfg_coef_i  = (mode == 0) ? DATA_W'(m_cnt + 1) : DATA_W'($urandom);
      cfg_start_i = v && (m_cnt == start_at);
      tick();
    end
    cfg_valid_i = 1'b0;
    cfg_start_i = 1'b0;
    chk("load_timeout", m_load, 0);
    chk("load_pending", ea_q.size(), 0);
  endtask

  task automatic run_load(input int mode, input int start_at);
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    beats(mode, start_at);
  endtask

  initial begin
    rst_i_sig   = 1'b1;
    cfg_start_i = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_coef_i  = '0;

    // Back-to-back load, data 1..11
    do_reset();
    run_load(0, -1);
    repeat (3) tick();

    // Valid every other cycle
    do_reset();
    run_load(1, -1);
    repeat (2) tick();

    // Second start at beat 5: sticky error, no restart
    do_reset();
    run_load(0, 5);
    repeat (3) tick();

    // Valid outside LOAD
    do_reset();
    cfg_valid_i = 1'b1;
    cfg_coef_i  = DATA_W'($urandom);
    tick();
    cfg_valid_i = 1'b0;
    repeat (2) tick();

    // Reset after beat 4 discards the partial load
    do_reset();
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid_i = 1'b1;
      cfg_coef_i  = DATA_W'($urandom);
      tick();
    end
    cfg_valid_i = 1'b0;
    do_reset();
    repeat (3) tick();
    run_load(2, -1);
    repeat (3) tick();

    // Several random loads, some starting right on the done cycle
    do_reset();
    for (int r = 0; r < 4; r++) begin
      run_load(2, -1);
      if (r[0]) tick();
    end
    repeat (2) tick();

`ifdef FIR_COEF_SCRUB_EN
    // Scrub after SCRUB_PERIOD idle cycles rewrites the stored coefficients
    do_reset();
    run_load(2, -1);
    repeat (15) tick();
    step();
    chk("scr_gap_we", we_o, 0);
    chk("scr_gap_busy", busy_o, 1);
    for (int j = 0; j <= ORD; j++) begin
      step();
      chk("scr_we", we_o, 1);
      chk("scr_addr", coef_addr_o, j);
      chk("scr_data", coef_o, m_shadow[j]);
      chk("scr_fir_en", fir_en_o, 1);
      chk("scr_done", done_o, 0);
      if (j < ORD) chk("scr_busy", busy_o, 1);
    end
    step();
    chk("scr_end_we", we_o, 0);
    chk("scr_end_busy", busy_o, 0);
    chk("scr_end_fir_en", fir_en_o, 1);

    // Start on scrub write 3 aborts the scrub
    do_reset();
    run_load(2, -1);
    repeat (15) tick();
    step();
    for (int j = 0; j <= 3; j++) step();
    chk("abort_addr3", coef_addr_o, 3);
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    chk("abort_we", we_o, 0);
    chk("abort_ready", cfg_ready_o, 1);
    chk("abort_fir_en", fir_en_o, 0);
    chk("abort_busy", busy_o, 1);
    m_load = 1; m_cnt = 0; m_fir_en = 0; en_pending = 0;
    beats(2, -1);
    repeat (3) tick();
`else
    // Without scrub, a long idle stretch after a load produces no writes
    do_reset();
    run_load(2, -1);
    repeat (40) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
